// File: rtl/slc3_types.sv
// rtl/slc3_types.sv - shared types and constants for the LC-3 board display path
// Contents:
//   scan_state_e          digit-scan FSM states, DIG0 = rightmost digit
//   DIGIT_CYCLES_DEFAULT  default number of clk cycles each digit is driven
//   SEG_GLYPH             16-entry active-high glyph table, bits 0..6 = segments a..g
//   grid_enable()         active-low one-cold grid pattern for a scan state
//   scan_next()           successor state in the scan ring
package slc3_types;

  typedef enum logic [1:0] {
    DIG0 = 2'd0,
    DIG1 = 2'd1,
    DIG2 = 2'd2,
    DIG3 = 2'd3
  } scan_state_e;

  localparam int DIGIT_CYCLES_DEFAULT = 50000;

  // Entry [15] first: F E d C b A 9 8 7 6 5 4 3 2 1 0.
  localparam logic [15:0][6:0] SEG_GLYPH = {
    7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
    7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
  };

  function automatic logic [3:0] grid_enable(input scan_state_e s);
    return ~(4'b0001 << s);
  endfunction

  function automatic scan_state_e scan_next(input scan_state_e s);
    case (s)
      DIG0:    return DIG1;
      DIG1:    return DIG2;
      DIG2:    return DIG3;
      default: return DIG0;
    endcase
  endfunction

endpackage

// File: rtl/hex_scan_driver_if.sv
// rtl/hex_scan_driver_if.sv - load bus between the display owner and the scan driver
// Signals:
//   hex_in     4x4 nibbles, index 0 = rightmost digit
//   dp_in      per-digit decimal point, 1 = lit
//   blank_in   per-digit blank, 1 = digit dark
//   load_i     single-cycle strobe capturing hex_in/dp_in/blank_in into the shadow
//   pending_o  shadow holds data not yet shown
// Modports: master drives the data and strobe, slave is the scan driver.
interface hex_scan_driver_if;

  logic [3:0][3:0] hex_in;
  logic [3:0]      dp_in;
  logic [3:0]      blank_in;
  logic            load_i;
  logic            pending_o;

  modport master (
    output hex_in,
    output dp_in,
    output blank_in,
    output load_i,
    input  pending_o
  );

  modport slave (
    input  hex_in,
    input  dp_in,
    input  blank_in,
    input  load_i,
    output pending_o
  );

endinterface

// File: rtl/hex_seg_decode.sv
// rtl/hex_seg_decode.sv - combinational nibble to seven-segment decode
// Ports:
//   nibble_i  hex digit to show
//   dp_i      decimal point, 1 = lit
//   blank_i   1 = force every segment and dp off
//   seg_o     active-high pattern, bits 0..6 = a..g, bit 7 = dp
module hex_seg_decode
  import slc3_types::*;
(
  input  logic [3:0] nibble_i,
  input  logic       dp_i,
  input  logic       blank_i,
  output logic [7:0] seg_o
);

  always_comb begin
    seg_o = {dp_i, SEG_GLYPH[nibble_i]};
    if (blank_i) begin
      seg_o = 8'h00;
    end
  end

endmodule

// File: rtl/hex_scan_driver.sv
// rtl/hex_scan_driver.sv - multiplexed 4-digit seven-segment scan driver with frame-aligned update
// Ports:
//   clk       system clock, the only clock used
//   reset     asynchronous active-low reset
//   ld        load bus (slave): hex_in, dp_in, blank_in, load_i in; pending_o out
//   hex_seg   registered segments a..g at bits 0..6, dp at bit 7; low-true when SEG_ACTIVE_LOW
//   hex_grid  registered digit enables, always active-low, bit n = digit n
// Parameters:
//   DIGIT_CYCLES    clk cycles each digit is driven (4..2^20)
//   SEG_ACTIVE_LOW  1 = segment/dp outputs low-true
module hex_scan_driver
  import slc3_types::*;
#(
  parameter int DIGIT_CYCLES   = DIGIT_CYCLES_DEFAULT,
  parameter bit SEG_ACTIVE_LOW = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  hex_scan_driver_if.slave ld,
  output logic [7:0]       hex_seg,
  output logic [3:0]       hex_grid
);

  localparam int               CNT_W    = $clog2(DIGIT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIGIT_CYCLES - 1);
  // XOR mask that turns an active-high pattern into the pin polarity;
  // applied to 8'h00 it is also the "all segments off" pin value.
  localparam logic [7:0]       SEG_OFF  = {8{SEG_ACTIVE_LOW}};

  // Prescaler and scan FSM
  logic [CNT_W-1:0] cnt_q, cnt_d;
  scan_state_e      state_q, state_d;
  logic [3:0]       grid_q, grid_d;
  logic [7:0]       seg_q, seg_d;

  // Shadow (written by loads) and display (read by the scan) registers
  logic [3:0][3:0]  shadow_hex_q, shadow_hex_d;
  logic [3:0]       shadow_dp_q, shadow_dp_d;
  logic [3:0]       shadow_blank_q, shadow_blank_d;
  logic [3:0][3:0]  disp_hex_q, disp_hex_d;
  logic [3:0]       disp_dp_q, disp_dp_d;
  logic [3:0]       disp_blank_q, disp_blank_d;
  logic             pending_q, pending_d;

  logic             tick;
  logic             frame_end;
  logic [1:0]       sel;
  logic [3:0]       cur_hex;
  logic             cur_dp;
  logic             cur_blank;
  logic [7:0]       seg_active;

  assign tick      = (cnt_q == CNT_LAST);
  assign frame_end = tick && (state_q == DIG3);

  // Digit mux: the current state picks which display nibble is decoded.
  assign sel       = state_q;
  assign cur_hex   = disp_hex_q[sel];
  assign cur_dp    = disp_dp_q[sel];
  assign cur_blank = disp_blank_q[sel];

  hex_seg_decode u_decode (
    .nibble_i (cur_hex),
    .dp_i     (cur_dp),
    .blank_i  (cur_blank),
    .seg_o    (seg_active)
  );

  // On a tick the state advances and both grid and segments go dark for one
  // cycle; the following edge lights the new digit with its own decode, so
  // grid and segments always move together and no digit ghosts into the next.
  always_comb begin
    cnt_d   = cnt_q + CNT_W'(1);
    state_d = state_q;
    grid_d  = grid_enable(state_q);
    seg_d   = seg_active ^ SEG_OFF;
    if (tick) begin
      cnt_d   = '0;
      state_d = scan_next(state_q);
      grid_d  = 4'hF;
      seg_d   = SEG_OFF;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q   <= '0;
      state_q <= DIG0;
      grid_q  <= 4'hF;
      seg_q   <= SEG_OFF;
    end else begin
      cnt_q   <= cnt_d;
      state_q <= state_d;
      grid_q  <= grid_d;
      seg_q   <= seg_d;
    end
  end

  // Transfer happens only when leaving DIG3 so a frame never mixes old and
  // new data. A load on that same edge lands in the shadow after the
  // transfer, so it keeps pending set and waits for the next boundary.
  always_comb begin
    shadow_hex_d   = shadow_hex_q;
    shadow_dp_d    = shadow_dp_q;
    shadow_blank_d = shadow_blank_q;
    disp_hex_d     = disp_hex_q;
    disp_dp_d      = disp_dp_q;
    disp_blank_d   = disp_blank_q;
    pending_d      = pending_q;
    if (frame_end && pending_q) begin
      disp_hex_d   = shadow_hex_q;
      disp_dp_d    = shadow_dp_q;
      disp_blank_d = shadow_blank_q;
      pending_d    = 1'b0;
    end
    if (ld.load_i) begin
      shadow_hex_d   = ld.hex_in;
      shadow_dp_d    = ld.dp_in;
      shadow_blank_d = ld.blank_in;
      pending_d      = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      shadow_hex_q   <= '0;
      shadow_dp_q    <= '0;
      shadow_blank_q <= 4'hF;
      disp_hex_q     <= '0;
      disp_dp_q      <= '0;
      disp_blank_q   <= 4'hF;
      pending_q      <= 1'b0;
    end else begin
      shadow_hex_q   <= shadow_hex_d;
      shadow_dp_q    <= shadow_dp_d;
      shadow_blank_q <= shadow_blank_d;
      disp_hex_q     <= disp_hex_d;
      disp_dp_q      <= disp_dp_d;
      disp_blank_q   <= disp_blank_d;
      pending_q      <= pending_d;
    end
  end

  assign hex_grid     = grid_q;
  assign hex_seg      = seg_q;
  assign ld.pending_o = pending_q;

endmodule

// File: tb/tb_hex_scan_driver.sv
// tb/tb_hex_scan_driver.sv - scoreboard bench for hex_scan_driver with DIGIT_CYCLES=4
module tb_hex_scan_driver;

  localparam int N = 4;

  typedef struct packed {
    logic [3:0] grid;
    logic [7:0] seg;
    logic       pend;
  } exp_t;

  typedef struct packed {
    int          cyc;
    logic [15:0] hex;
    logic [3:0]  dp;
    logic [3:0]  blank;
  } load_t;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] hex_seg;
  logic [3:0] hex_grid;

  hex_scan_driver_if ld();

  hex_scan_driver #(
    .DIGIT_CYCLES   (N),
    .SEG_ACTIVE_LOW (1'b1)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .ld       (ld),
    .hex_seg  (hex_seg),
    .hex_grid (hex_grid)
  );

  always #5 clk = ~clk;

  int              n_checks = 0;
  int              n_pass   = 0;
  exp_t            exp_q[$];
  logic [3:0][7:0] seg_tab [8];
  logic [3:0]      pnd_tab [8];
  load_t           load_tab [10];
  logic [3:0][3:0] grid_tab;
  logic [3:0][7:0] dark_segs;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
  endtask

  task automatic push_frame(input logic [3:0][7:0] segs, input logic [3:0] pnds, input int ndig);
    exp_t e;
    for (int d = 0; d < ndig; d++) begin
      e.grid = grid_tab[d];
      e.seg  = segs[d];
      e.pend = pnds[d];
      exp_q.push_back(e);
    end
  endtask

  task automatic drive_loads(input int c);
    ld.load_i = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (load_tab[i].cyc == c) begin
        ld.load_i   = 1'b1;
        ld.hex_in   = load_tab[i].hex;
        ld.dp_in    = load_tab[i].dp;
        ld.blank_in = load_tab[i].blank;
      end
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_grid"}, 32'(hex_grid), 32'h0000000F);
    check({tag, "_seg"}, 32'(hex_seg), 32'h000000FF);
    check({tag, "_pending"}, 32'(ld.pending_o), 32'h00000000);
  endtask

  // Monitor: a digit is presented when the grid leaves the all-high blank
  // state; each presentation pops one expectation.
  initial begin : monitor
    logic [3:0] prev_grid;
    logic [7:0] prev_seg;
    int         mcyc;
    int         last_pres;
    int         run;
    exp_t       e;
    prev_grid = 4'hF;
    prev_seg  = 8'hFF;
    mcyc      = 0;
    last_pres = -1;
    run       = 0;
    forever begin
      @(negedge clk);
      mcyc++;
      if (reset !== 1'b1) begin
        prev_grid = 4'hF;
        last_pres = -1;
        run       = 0;
      end else begin
        if (hex_grid != 4'hF) begin
          if (prev_grid == 4'hF) begin
            check("sb_depth", 32'(exp_q.size() > 0), 32'd1);
            if (exp_q.size() > 0) begin
              e = exp_q.pop_front();
              check("grid", 32'(hex_grid), 32'(e.grid));
              check("seg", 32'(hex_seg), 32'(e.seg));
              check("pending", 32'(ld.pending_o), 32'(e.pend));
            end
            if (last_pres >= 0) check("digit_period", 32'(mcyc - last_pres), 32'(N));
            last_pres = mcyc;
            run       = 1;
          end else begin
            check("grid_hold", 32'(hex_grid), 32'(prev_grid));
            check("seg_hold", 32'(hex_seg), 32'(prev_seg));
            run++;
          end
        end else if (prev_grid != 4'hF) begin
          check("lit_cycles", 32'(run), 32'(N - 1));
          check("blank_seg_off", 32'(hex_seg), 32'h000000FF);
        end
        prev_grid = hex_grid;
        prev_seg  = hex_seg;
      end
    end
  end

  initial begin : watchdog
    #100000;
    $display("FAIL timeout: still running at 100000 ns, required finish earlier");
    $fatal(1, "timeout");
  end

  initial begin : stim
    grid_tab  = {4'b0111, 4'b1011, 4'b1101, 4'b1110};
    dark_segs = {8'hFF, 8'hFF, 8'hFF, 8'hFF};

    // Expected active-low segments per frame, packed {digit3, digit2, digit1, digit0}.
    seg_tab[0] = {8'hFF, 8'hFF, 8'hFF, 8'hFF};   // reset contents: all blank
    seg_tab[1] = {8'h8E, 8'hC0, 8'hA4, 8'h88};   // F 0 2 A
    seg_tab[2] = {8'hC6, 8'h06, 8'h82, 8'h10};   // C E. 6 9.
    seg_tab[3] = {8'hC6, 8'h06, 8'h82, 8'h10};   // still C E. 6 9. (boundary load waits)
    seg_tab[4] = {8'hF8, 8'h92, 8'h83, 8'h80};   // 7 5 b 8
    seg_tab[5] = {8'hB0, 8'hB0, 8'hB0, 8'hB0};   // 3 3 3 3, last of three loads
    seg_tab[6] = {8'hFF, 8'h24, 8'hFF, 8'h40};   // dark 2. dark 0.
    seg_tab[7] = {8'hFF, 8'h24, 8'hFF, 8'h40};
    pnd_tab[0] = 4'b1111;
    pnd_tab[1] = 4'b1100;
    pnd_tab[2] = 4'b0000;
    pnd_tab[3] = 4'b1111;
    pnd_tab[4] = 4'b1110;
    pnd_tab[5] = 4'b1110;
    pnd_tab[6] = 4'b0000;
    pnd_tab[7] = 4'b0110;

    load_tab[0] = '{cyc: 0,   hex: 16'hF02A, dp: 4'b0000, blank: 4'b0000};
    load_tab[1] = '{cyc: 21,  hex: 16'hCE69, dp: 4'b0101, blank: 4'b0000};
    load_tab[2] = '{cyc: 47,  hex: 16'h75B8, dp: 4'b0000, blank: 4'b0000};
    load_tab[3] = '{cyc: 66,  hex: 16'h1111, dp: 4'b0000, blank: 4'b0000};
    load_tab[4] = '{cyc: 70,  hex: 16'h2222, dp: 4'b0000, blank: 4'b0000};
    load_tab[5] = '{cyc: 75,  hex: 16'h3333, dp: 4'b0000, blank: 4'b0000};
    load_tab[6] = '{cyc: 76,  hex: 16'h3333, dp: 4'b0000, blank: 4'b0000};
    load_tab[7] = '{cyc: 77,  hex: 16'h3333, dp: 4'b0000, blank: 4'b0000};
    load_tab[8] = '{cyc: 82,  hex: 16'h3210, dp: 4'b1111, blank: 4'b1010};
    load_tab[9] = '{cyc: 113, hex: 16'h8888, dp: 4'b1111, blank: 4'b0000};

    reset       = 1'b0;
    ld.load_i   = 1'b0;
    ld.hex_in   = '0;
    ld.dp_in    = '0;
    ld.blank_in = '0;
    repeat (3) @(negedge clk);
    check_reset_outputs("por");

    // Cycle c runs from the negedge where it is entered to the next one;
    // reset is released at the start of cycle 0, so frame f spans 16f..16f+15.
    reset = 1'b1;
    for (int c = 0; c < 122; c++) begin
      if (c > 0) @(negedge clk);
      if (c % 16 == 0) push_frame(seg_tab[c / 16], pnd_tab[c / 16], (c / 16 == 7) ? 3 : 4);
      drive_loads(c);
    end

    // Cycle 121 is in DIG2 of frame 7 with a pending load.
    #2;
    reset = 1'b0;
    #1;
    check_reset_outputs("async_rst");
    check("sb_drained_1", 32'(exp_q.size()), 32'd0);
    repeat (3) @(negedge clk);
    check_reset_outputs("rst_hold");

    reset = 1'b1;
    for (int c = 0; c < 33; c++) begin
      if (c > 0) @(negedge clk);
      if (c == 0 || c == 16) push_frame(dark_segs, 4'b0000, 4);
    end
    check("sb_drained_2", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
